// File: rtl/intersection_sequencer.sv
// Two-road intersection sequencer with a pedestrian crossing. The main road rests on green.
// The side road and the crossing are served on demand, with phases timed in prescaler ticks.
module intersection_sequencer #(
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_SIDE = 6,
    parameter int YELLOW     = 3,
    parameter int ALLRED     = 1,
    parameter int WALK       = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       side_car,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [2:0] MAIN_GREEN  = 3'd0;
    localparam logic [2:0] MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_A   = 3'd2;
    localparam logic [2:0] SIDE_GREEN  = 3'd3;
    localparam logic [2:0] SIDE_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B   = 3'd5;
    localparam logic [2:0] PED_WALK    = 3'd6;

    // Terminal timer values: a phase of D ticks ends on the tick seen at D-1.
    localparam logic [CNT_W-1:0] TIMER_MAX       = '1;
    localparam logic [CNT_W-1:0] GREEN_MIN_LAST  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GREEN_SIDE_LAST = CNT_W'(GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST     = CNT_W'(ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST       = CNT_W'(WALK - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            MAIN_GREEN:
                if (tick && timer >= GREEN_MIN_LAST && (side_car || ped_pending))
                    state_nxt = MAIN_YELLOW;
            MAIN_YELLOW:
                if (tick && timer == YELLOW_LAST)
                    state_nxt = ALL_RED_A;
            ALL_RED_A:
                if (tick && timer == ALLRED_LAST)
                    state_nxt = ped_pending ? PED_WALK : SIDE_GREEN;
            PED_WALK:
                if (tick && timer == WALK_LAST)
                    state_nxt = side_car ? SIDE_GREEN : ALL_RED_B;
            SIDE_GREEN:
                if (tick && timer == GREEN_SIDE_LAST)
                    state_nxt = SIDE_YELLOW;
            SIDE_YELLOW:
                if (tick && timer == YELLOW_LAST)
                    state_nxt = ALL_RED_B;
            ALL_RED_B:
                if (tick && timer == ALLRED_LAST)
                    state_nxt = MAIN_GREEN;
            default:
                state_nxt = MAIN_GREEN;
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it appears only inside the clocked block.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= MAIN_GREEN;
            timer       <= '0;
            ped_pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all three registers updating from pre-edge values.
            state <= state_nxt;

            if (state_nxt != state)
                timer <= '0;
            else if (tick && timer != TIMER_MAX)
                timer <= timer + 1'b1;

            // Entering the walk phase consumes the request and wins over a same-cycle press.
            if (state_nxt == PED_WALK && state != PED_WALK)
                ped_pending <= 1'b0;
            else if (ped_req && state != PED_WALK)
                ped_pending <= 1'b1;
        end
    end

    always_comb begin
        main_red    = 1'b1;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b1;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        walk        = 1'b0;
        case (state)
            MAIN_GREEN: begin
                main_red   = 1'b0;
                main_green = 1'b1;
            end
            MAIN_YELLOW: begin
                main_red    = 1'b0;
                main_yellow = 1'b1;
            end
            SIDE_GREEN: begin
                side_red   = 1'b0;
                side_green = 1'b1;
            end
            SIDE_YELLOW: begin
                side_red    = 1'b0;
                side_yellow = 1'b1;
            end
            PED_WALK:
                walk = 1'b1;
            default: ;
        endcase
    end

    assign phase = state;

endmodule
